// File: rtl/uart_rx_frame_engine.sv
// uart_rx_frame_engine: oversampled UART receiver with per-frame parity/framing/break checks
// feeding a first-word-fall-through status FIFO of {BI, FE, PE, data} entries.
module uart_rx_frame_engine #(
  parameter int PDATA_WIDTH = 8,
  parameter int OSR = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                         PCLK,
  input  logic                         PRESET,
  input  logic                         baud_tick,
  input  logic                         sRX,
  input  logic [1:0]                   charl,
  input  logic                         stop_sel,
  input  logic                         par_en,
  input  logic                         par_sel,
  input  logic                         stick_par,
  input  logic                         rd_en,
  input  logic                         ovr_clr,
  output logic [PDATA_WIDTH+2:0]       rd_data,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(FIFO_DEPTH):0]  count,
  output logic                         overrun,
  output logic                         frame_done,
  output logic                         busy
);
  localparam int CW = $clog2(OSR);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;
  localparam logic [CW-1:0] HALF = CW'(OSR / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OSR - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRKWAIT} state_t;

  state_t                 state_q, state_d;
  logic                   rx_meta_q, rx_s_q, rx_prev_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [3:0]             bit_q, bit_d;
  logic [PDATA_WIDTH-1:0] sh_q, sh_d;
  logic [1:0]             charl_q, charl_d;
  logic                   pen_q, pen_d, psel_q, psel_d, stick_q, stick_d;
  logic                   pbit_q, pbit_d, pe_q, pe_d;
  logic                   frame_done_q, frame_done_d, busy_q, busy_d;
  logic                   overrun_q, overrun_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]          count_q, count_d;
  logic [PDATA_WIDTH+2:0] mem_q [FIFO_DEPTH];
  logic                   samp, push, wr_ok, rd_ok, fe, bi;
  logic [PDATA_WIDTH+2:0] wdata;
  logic                   unused_stop_sel;

  assign unused_stop_sel = stop_sel;
  assign fe = !rx_s_q;
  assign bi = fe && sh_q == '0 && !(pen_q && pbit_q);
  assign wdata = {bi, fe, pe_q, sh_q};
  assign empty = count_q == '0;
  assign full = count_q == NW'(FIFO_DEPTH);
  assign count = count_q;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
  assign overrun = overrun_q;
  assign frame_done = frame_done_q;
  assign busy = busy_q;

  always_comb begin
    state_d = state_q;
    bit_d = bit_q;
    sh_d = sh_q;
    charl_d = charl_q;
    pen_d = pen_q;
    psel_d = psel_q;
    stick_d = stick_q;
    pbit_d = pbit_q;
    pe_d = pe_q;
    push = 1'b0;
    samp = baud_tick && cnt_q == (state_q == START ? HALF : LAST);
    cnt_d = (state_q == IDLE || state_q == BRKWAIT) ? '0 : baud_tick ? (samp ? '0 : cnt_q + 1'b1) : cnt_q;
    case (state_q)
      IDLE: state_d = (rx_prev_q && !rx_s_q) ? START : IDLE;
      START: if (samp && rx_s_q) state_d = IDLE;
        else if (samp) begin
          state_d = DATA;
          charl_d = charl;
          pen_d = par_en;
          psel_d = par_sel;
          stick_d = stick_par;
          sh_d = '0;
          bit_d = '0;
          pbit_d = 1'b0;
          pe_d = 1'b0;
        end
      DATA: if (samp) begin
        for (int i = 0; i < PDATA_WIDTH; i++) if (bit_q == 4'(i)) sh_d[i] = rx_s_q;
        bit_d = bit_q + 1'b1;
        if (bit_q == {2'b01, charl_q}) state_d = pen_q ? PARITY : STOP;
      end
      PARITY: if (samp) begin
        pbit_d = rx_s_q;
        pe_d = rx_s_q != (stick_q ? !psel_q : psel_q ? ^sh_q : ~^sh_q);
        state_d = STOP;
      end
      STOP: if (samp) begin
        push = 1'b1;
        state_d = rx_s_q ? IDLE : BRKWAIT;
      end
      BRKWAIT: state_d = rx_s_q ? IDLE : BRKWAIT;
      default: state_d = IDLE;
    endcase
    // A full FIFO still accepts the word when the same cycle pops the head
    rd_ok = rd_en && !empty;
    wr_ok = push && (!full || rd_en);
    wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d = count_q + NW'(wr_ok) - NW'(rd_ok);
    overrun_d = (push && full && !rd_en) || (overrun_q && !ovr_clr);
    frame_done_d = push;
    busy_d = state_d != IDLE;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q <= 1'b1;
      rx_prev_q <= 1'b1;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      charl_q <= '0;
      pen_q <= 1'b0;
      psel_q <= 1'b0;
      stick_q <= 1'b0;
      pbit_q <= 1'b0;
      pe_q <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q <= 1'b0;
      overrun_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      rx_meta_q <= sRX;
      rx_s_q <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      charl_q <= charl_d;
      pen_q <= pen_d;
      psel_q <= psel_d;
      stick_q <= stick_d;
      pbit_q <= pbit_d;
      pe_q <= pe_d;
      frame_done_q <= frame_done_d;
      busy_q <= busy_d;
      overrun_q <= overrun_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge PCLK) if (wr_ok) mem_q[wr_ptr_q] <= wdata;
endmodule

// File: tb/tb_uart_rx_frame_engine.sv
// tb_uart_rx_frame_engine: directed and random UART frames checked through an expected-entry
// scoreboard queue that a free-running monitor drains from the FIFO.
module tb_uart_rx_frame_engine;
  localparam int OSR = 16;
  localparam int TDIV = 3;
  localparam int BIT = OSR * TDIV;

  logic PCLK = 0, PRESET = 1, baud_tick = 0, sRX = 1;
  logic [1:0] charl = 2'b11;
  logic stop_sel = 0, par_en = 0, par_sel = 0, stick_par = 0, rd_en = 0, ovr_clr = 0;
  logic [10:0] rd_data;
  logic empty, full, overrun, frame_done, busy;
  logic [4:0] count;
  logic [10:0] exp_q[$];
  int n_vec = 0, n_bad = 0, fd_cnt = 0, exp_fd = 0;
  bit mon_en = 0, man_pop = 0;

  uart_rx_frame_engine dut (
    .PCLK(PCLK), .PRESET(PRESET), .baud_tick(baud_tick), .sRX(sRX), .charl(charl),
    .stop_sel(stop_sel), .par_en(par_en), .par_sel(par_sel), .stick_par(stick_par),
    .rd_en(rd_en), .ovr_clr(ovr_clr), .rd_data(rd_data), .empty(empty), .full(full),
    .count(count), .overrun(overrun), .frame_done(frame_done), .busy(busy)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected entry from the line-level view of a frame: what bits were put on the wire
  function automatic logic [10:0] model(input logic [7:0] d, input int n, input bit pen, input bit psel,
                                        input bit stick, input bit pbit, input bit sbit);
    logic [7:0] dm;
    bit odd, exp_p;
    dm = d & 8'((1 << n) - 1);
    odd = ($countones(dm) % 2) == 1;
    exp_p = stick ? !psel : (psel ? odd : !odd);
    return {dm == 8'd0 && !(pen && pbit) && !sbit, !sbit, pen && (pbit != exp_p), dm};
  endfunction

  initial forever begin
    repeat (TDIV - 1) @(negedge PCLK);
    baud_tick = 1;
    @(negedge PCLK);
    baud_tick = 0;
  end

  initial forever begin
    @(negedge PCLK);
    if (frame_done) fd_cnt++;
    if (!empty && (mon_en || man_pop)) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected entry: got %0h, expected none", rd_data);
      end else chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
      rd_en = 1;
    end else rd_en = 0;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic drive_bit(input logic v);
    sRX = v;
    repeat (BIT) @(negedge PCLK);
  endtask

  task automatic send(input logic [7:0] d, input logic [1:0] cl, input bit pen, input bit psel, input bit stick,
                      input bit pbit, input bit sbit, input bit keep = 1, input bit scramble = 0);
    int n = 5 + int'(cl);
    charl = cl;
    par_en = pen;
    par_sel = psel;
    stick_par = stick;
    if (keep) exp_q.push_back(model(d, n, pen, psel, stick, pbit, sbit));
    exp_fd++;
    drive_bit(0);
    if (scramble) begin
      charl = 2'($urandom);
      par_en = 1'($urandom);
      par_sel = 1'($urandom);
      stick_par = 1'($urandom);
    end
    for (int i = 0; i < n; i++) drive_bit(d[i]);
    if (pen) drive_bit(pbit);
    drive_bit(sbit);
    sRX = 1;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || !empty) && t < 4 * BIT) begin
      @(negedge PCLK);
      t++;
    end
    chk("drain queue", exp_q.size(), 0);
    chk("drain empty", empty, 1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " frame_done"}, frame_done, 0);
    chk({tag, " overrun"}, overrun, 0);
    chk({tag, " empty"}, empty, 1);
    chk({tag, " full"}, full, 0);
    chk({tag, " count"}, count, 0);
    chk({tag, " rd_data"}, rd_data, 0);
  endtask

  initial begin
    bit sb;
    repeat (4) @(negedge PCLK);
    chk_reset("reset");
    PRESET = 0;
    repeat (BIT) @(negedge PCLK);

    send(8'hA5, 2'b11, 0, 0, 0, 0, 1);
    chk("8N1 count", count, 1);
    chk("8N1 frame_done", fd_cnt, exp_fd);
    mon_en = 1;
    drain();

    send(8'h41, 2'b10, 1, 1, 0, 1, 1);
    send(8'h41, 2'b10, 1, 0, 0, 0, 1);
    drain();

    exp_q.push_back(model(8'h00, 8, 0, 0, 0, 0, 0));
    exp_fd++;
    charl = 2'b11;
    par_en = 0;
    sRX = 0;
    repeat (11 * BIT) @(negedge PCLK);
    chk("break busy low line", busy, 1);
    repeat (BIT) @(negedge PCLK);
    sRX = 1;
    repeat (2 * BIT) @(negedge PCLK);
    chk("break busy after rise", busy, 0);
    chk("break frame_done", fd_cnt, exp_fd);
    drain();

    sRX = 0;
    repeat (OSR / 4 * TDIV) @(negedge PCLK);
    sRX = 1;
    repeat (2 * BIT) @(negedge PCLK);
    chk("false start busy", busy, 0);
    chk("false start frame_done", fd_cnt, exp_fd);
    chk("false start empty", empty, 1);
    send(8'h3C, 2'b11, 0, 0, 0, 0, 1);
    drain();

    mon_en = 0;
    for (int i = 0; i < 17; i++) send(8'($urandom), 2'b00, 0, 0, 0, 0, 1, i < 16);
    chk("overrun count", count, 16);
    chk("overrun full", full, 1);
    chk("overrun flag", overrun, 1);
    chk("overrun frame_done", fd_cnt, exp_fd);
    ovr_clr = 1;
    @(negedge PCLK);
    ovr_clr = 0;
    chk("ovr_clr", overrun, 0);
    @(posedge PCLK);
    man_pop = 1;
    @(posedge PCLK);
    man_pop = 0;
    @(negedge PCLK);
    chk("pop count", count, 15);
    chk("pop full", full, 0);
    mon_en = 1;
    drain();

    mon_en = 0;
    send(8'h5A, 2'b11, 0, 0, 0, 0, 1);
    chk("pre-abort count", count, 1);
    charl = 2'b11;
    drive_bit(0);
    drive_bit(1);
    drive_bit(0);
    drive_bit(1);
    PRESET = 1;
    sRX = 1;
    repeat (3) @(negedge PCLK);
    exp_q.delete();
    chk_reset("abort");
    PRESET = 0;
    repeat (BIT) @(negedge PCLK);
    chk("abort frame_done", fd_cnt, exp_fd);
    mon_en = 1;
    send(8'hFF, 2'b11, 1, 1, 1, 0, 1);
    drain();

    for (int k = 0; k < 30; k++) begin
      sb = $urandom_range(0, 7) != 0;
      send(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), sb, 1, 1);
      if (!sb || $urandom_range(0, 1) == 1) drive_bit(1);
    end
    drain();
    chk("total frame_done", fd_cnt, exp_fd);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
